// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic add/multiply sequencer.
// Holds the FSM state encoding, combiner mode codes and the 8-bit LFSR tap mask.
package stoch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_MUL   = 2'b00;
    localparam logic [1:0] MODE_ADD   = 2'b01;
    localparam logic [1:0] MODE_PASSA = 2'b10;
    localparam logic [1:0] MODE_PASSB = 2'b11;

    // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: xor of bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;

endpackage

// File: rtl/stoch_lfsr.sv
// Fibonacci LFSR, one step per cycle when en is high; load restores SEED.
// load wins over en; the register never leaves the nonzero cycle for a nonzero SEED.
module stoch_lfsr #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(stoch_pkg::LFSR_TAPS_8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = SEED;
        end else if (en) begin
            value_d = {value_q[WIDTH-2:0], ^(value_q & TAPS)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/stoch_seq_ctrl.sv
// Stochastic datapath sequencer: latch operands on start, stream for one LFSR period, count ones.
// done is asserted 2^WIDTH-1 cycles into the run; start is ignored unless IDLE (no queuing).
module stoch_seq_ctrl
    import stoch_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] SEED_A = 8'h01,
    parameter logic [WIDTH-1:0] SEED_B = 8'h5A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] LAST_CNT = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ones_q, ones_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [1:0]       mode_q, mode_d;

    logic             lfsr_load;
    logic             lfsr_en;
    logic [WIDTH-1:0] lfsr_a;
    logic [WIDTH-1:0] lfsr_b;
    logic             bit_a;
    logic             bit_b;
    logic             stream_bit;

    stoch_lfsr #(.WIDTH(WIDTH), .SEED(SEED_A)) u_lfsr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .value (lfsr_a)
    );

    stoch_lfsr #(.WIDTH(WIDTH), .SEED(SEED_B)) u_lfsr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .value (lfsr_b)
    );

    // The LFSR covers 1..2^WIDTH-1 once per run, so "<=" yields exactly op ones.
    assign bit_a = (lfsr_a <= op_a_q);
    assign bit_b = (lfsr_b <= op_b_q);

    always_comb begin
        stream_bit = 1'b0;
        case (mode_q)
            MODE_MUL:   stream_bit = bit_a & bit_b;
            MODE_ADD:   stream_bit = cnt_q[0] ? bit_b : bit_a;
            MODE_PASSA: stream_bit = bit_a;
            MODE_PASSB: stream_bit = bit_b;
            default:    stream_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ones_d    = ones_q;
        result_d  = result_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        mode_d    = mode_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    op_a_d    = op_a;
                    op_b_d    = op_b;
                    mode_d    = mode;
                    cnt_d     = '0;
                    ones_d    = '0;
                    lfsr_load = 1'b1;
                end
            end
            RUN: begin
                lfsr_en = 1'b1;
                cnt_d   = cnt_q + ONE;
                if (stream_bit) begin
                    ones_d = ones_q + ONE;
                end
                // Capture including the final bit so result is valid alongside done.
                if (cnt_q == LAST_CNT) begin
                    state_d  = DONE;
                    result_d = ones_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ones_q   <= '0;
            result_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            mode_q   <= MODE_MUL;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            result_q <= result_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            mode_q   <= mode_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_stoch_seq_ctrl.sv
// Directed bench for stoch_seq_ctrl using only the exact cases (pass modes, multiply by max, add extremes).
module tb_stoch_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    stoch_seq_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // lat = edge index (start edge = 0) at which a clocked consumer first sees done high.
    task automatic run_op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int res);
        @(negedge clk);
        mode  = m;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        res = -1;
        for (int k = 1; k < 400 && lat < 0; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                res = int'(result);
            end
        end
    endtask

    int lat;
    int res;
    int pulses;
    int t_done[3];
    int r_done[3];
    int nd;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        op_a  = 8'd0;
        op_b  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        rst = 1'b0;

        // Pass A: latency, value, busy drops afterwards
        run_op(2'b10, 8'd100, 8'd3, lat, res);
        check("passa_latency", lat, 256);
        check("passa_result", res, 100);
        @(negedge clk);
        check("passa_busy_after", int'(busy), 0);
        check("passa_done_after", int'(done), 0);
        check("passa_result_hold", int'(result), 100);

        // Reset while idle clears the held result
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_rst_result", int'(result), 0);
        check("idle_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b11, 8'd9, 8'd200, lat, res);
        check("passb_result", res, 200);

        run_op(2'b00, 8'd77, 8'd255, lat, res);
        check("mul_77x255", res, 77);
        run_op(2'b00, 8'd255, 8'd123, lat, res);
        check("mul_255x123", res, 123);
        run_op(2'b00, 8'd0, 8'd200, lat, res);
        check("mul_0x200", res, 0);

        run_op(2'b01, 8'd255, 8'd255, lat, res);
        check("add_max_max", res, 255);
        run_op(2'b01, 8'd0, 8'd0, lat, res);
        check("add_zero_zero", res, 0);
        run_op(2'b01, 8'd255, 8'd0, lat, res);
        check("add_max_zero", res, 128);
        run_op(2'b01, 8'd0, 8'd255, lat, res);
        check("add_zero_max", res, 127);

        // Changes and start during RUN are ignored; result held from previous run meanwhile
        @(negedge clk);
        mode  = 2'b10;
        op_a  = 8'd150;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        res = -1;
        for (int k = 1; k < 600; k++) begin
            @(negedge clk);
            if (k == 40) begin
                op_a  = 8'd5;
                mode  = 2'b11;
                op_b  = 8'd17;
                start = 1'b1;
            end
            if (k == 42) start = 1'b0;
            if (k == 100) check("hold_prev_result", int'(result), 127);
            if (k == 100) check("busy_in_run", int'(busy), 1);
            if (done) begin
                pulses++;
                res = int'(result);
            end
        end
        check("ignore_result", res, 150);
        check("ignore_pulses", pulses, 1);

        // Start held continuously: back-to-back runs 257 cycles apart
        @(negedge clk);
        mode  = 2'b10;
        op_a  = 8'd33;
        start = 1'b1;
        nd = 0;
        for (int k = 0; k < 1200 && nd < 3; k++) begin
            @(negedge clk);
            if (done) begin
                t_done[nd] = k;
                r_done[nd] = int'(result);
                nd++;
            end
        end
        start = 1'b0;
        check("held_count", nd, 3);
        if (nd == 3) begin
            check("held_gap1", t_done[1] - t_done[0], 257);
            check("held_gap2", t_done[2] - t_done[1], 257);
            for (int i = 0; i < 3; i++) check("held_result", r_done[i], 33);
        end
        repeat (3) @(negedge clk);
        check("held_idle_after", int'(busy), 0);

        // Reset mid-RUN: outputs clear at once and no done follows
        run_op(2'b10, 8'd60, 8'd0, lat, res);
        check("pre_rst_result", res, 60);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("midrun_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrun_rst_busy", int'(busy), 0);
        check("midrun_rst_done", int'(done), 0);
        check("midrun_rst_result", int'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrun_no_done", pulses, 0);

        run_op(2'b10, 8'd255, 8'd0, lat, res);
        check("after_rst_passa_max", res, 255);
        check("after_rst_latency", lat, 256);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
